wb_obi_bridge: RTL and testbench
================================

WB_OBI_BRIDGE -- requirements
Module: wb_obi_bridge

Interface
REQ-001 Parameters SHALL be: ADDR_W, default 32, address width; DATA_W, default 32, data width; ADDR_BASE, default 32'h0000_0000, OBI address high bits (bits [19:0] zero); TIMEOUT, default 256, max cycles per OBI phase.
REQ-002 Ports SHALL be, as name direction width meaning, starting with clk_i in 1 single clock; one clock; reset is synchronous and active-low.
REQ-003 rst_ni in 1: synchronous active-low reset.
REQ-004 en in 1: accept enable.
REQ-005 Wishbone slave ports: wb_cyc_i in 1; wb_stb_i in 1; wb_addr_i in ADDR_W; wb_wdata_i in DATA_W; wb_wr_en_i in 1; wb_byte_en_i in DATA_W/8; wb_rdata_o out DATA_W; wb_ack_o out 1; wb_err_o out 1.
REQ-006 OBI master ports: obi_req_o out 1; obi_gnt_i in 1; obi_addr_o out ADDR_W; obi_wr_en_o out 1; obi_byte_en_o out DATA_W/8; obi_wdata_o out DATA_W; obi_rvalid_i in 1; obi_rdata_i in DATA_W.

Function
REQ-007 The FSM SHALL have states IDLE, REQ, RESP, ACK, ERR, DRAIN_GNT, DRAIN_RSP, with at most one outstanding OBI transaction.
REQ-008 IDLE: if wb_cyc_i & wb_stb_i & en, the bridge SHALL register obi_addr_o={ADDR_BASE[ADDR_W-1:20], wb_addr_i[19:0]}, the wdata, wr_en and byte_en, clear the phase counter, and go to REQ.
REQ-009 REQ: obi_req_o SHALL be 1, with all OBI request fields stable; on obi_gnt_i the FSM SHALL go to RESP and clear the counter.
REQ-010 RESP: on obi_rvalid_i, wb_rdata_o SHALL capture obi_rdata_i (writes included) and the FSM SHALL go to ACK.
REQ-011 ACK: wb_ack_o SHALL be 1 for exactly one cycle, and the next state SHALL be IDLE.
REQ-012 ERR: wb_err_o SHALL be 1 for exactly one cycle, and the next state SHALL be DRAIN_GNT if a grant is still owed, else DRAIN_RSP.
REQ-013 Minimum latency SHALL be: stb sampled at edge N, gnt in the first REQ cycle, rvalid in the first RESP cycle, wb_ack_o high in cycle N+3.
REQ-014 Timeout: the counter SHALL increment each cycle in REQ/RESP; on reaching TIMEOUT-1 without gnt/rvalid, the FSM SHALL go to ERR.
REQ-015 OBI protocol: obi_req_o SHALL NOT drop before gnt; after a timeout in REQ, DRAIN_GNT SHALL hold obi_req_o=1 until gnt, then go to DRAIN_RSP.
REQ-016 DRAIN_RSP SHALL wait for obi_rvalid_i, discard the data, and go to IDLE; no Wishbone response SHALL be given in either drain state.
REQ-017 WB abort: if wb_cyc_i drops in REQ, the FSM SHALL go to DRAIN_GNT; if it drops in RESP, it SHALL go to DRAIN_RSP. No ack or err SHALL be issued.
REQ-018 Simultaneous events: gnt or rvalid in the timeout cycle SHALL take priority over the timeout. Abort in the same cycle as gnt SHALL go to DRAIN_RSP.
REQ-019 en SHALL gate only acceptance in IDLE; deasserting it mid-transaction SHALL have no effect.
REQ-020 wb_ack_o and wb_err_o SHALL never be high together, and never outside the ACK/ERR states.
REQ-021 The counter SHALL be $clog2(TIMEOUT) bits wide and SHALL saturate, never wrap.

Reset
REQ-022 On rst_ni=0 at a clk_i edge: state SHALL be IDLE; obi_req_o, wb_ack_o, wb_err_o, obi_wr_en_o=0; obi_byte_en_o, obi_addr_o, obi_wdata_o, wb_rdata_o=0; counter=0.
REQ-023 A reset mid-transaction SHALL abandon it immediately, with no drain; the system resets the OBI slave together with the bridge.

Structure
REQ-024 Package wb_obi_bridge_pkg SHALL hold the state enum and the default TIMEOUT constant.
REQ-025 The phase timeout counter SHALL be sub-module wb_obi_timeout (clear, enable, expired); everything else SHALL stay flat.

Verification
REQ-026 Read: wb_addr_i=32'hABC1_2344, ADDR_BASE=32'h4000_0000, gnt immediate, rvalid 2 cycles later with 32'hDEAD_BEEF -> obi_addr_o=32'h4001_2344; one-cycle wb_ack_o with wb_rdata_o=32'hDEAD_BEEF.
REQ-027 Write: byte_en=4'b0101, wdata=32'h1234_5678 -> identical OBI fields; obi_req_o held 5 cycles until gnt; single wb_ack_o.
REQ-028 Gnt timeout: TIMEOUT=8, gnt withheld -> wb_err_o in cycle 9 after acceptance; obi_req_o stays 1 until gnt at cycle 20; rvalid consumed; no ack; return to IDLE.
REQ-029 Abort: wb_cyc_i drops in RESP -> no ack/err; rvalid 3 cycles later consumed; next Wishbone request is then accepted normally.
REQ-030 Edge cases: gnt in the counter's TIMEOUT-1 cycle -> no error; en=0 with stb high -> obi_req_o stays 0; reset asserted in RESP -> all outputs 0 on the next edge.

Source files
------------

// File: rtl/wb_obi_bridge_pkg.sv
// Shared types and constants for the Wishbone-to-OBI bridge.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package wb_obi_bridge_pkg;

    // Bridge control states; at most one OBI transaction is ever in flight.
    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_REQ       = 3'd1,
        S_RESP      = 3'd2,
        S_ACK       = 3'd3,
        S_ERR       = 3'd4,
        S_DRAIN_GNT = 3'd5,
        S_DRAIN_RSP = 3'd6
    } state_e;

    // Default per-phase cycle budget before the Wishbone side gets an error.
    localparam int unsigned TIMEOUT_DEFAULT = 256;

endpackage

// File: rtl/wb_obi_timeout.sv
// Phase timeout counter: counts enabled cycles since the last clear and flags TIMEOUT-1.
// Latency: expired_o is a combinational decode of the registered count.
// Backpressure: none; the counter saturates at TIMEOUT-1 instead of wrapping.
//
// Ports:
//   clk_i      single clock
//   rst_ni     synchronous active-low reset
//   clear_i    restart the count at zero (wins over en_i)
//   en_i       count this cycle
//   expired_o  count has reached TIMEOUT-1
module wb_obi_timeout
    import wb_obi_bridge_pkg::*;
#(
    parameter int unsigned TIMEOUT = TIMEOUT_DEFAULT
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic clear_i,
    input  logic en_i,
    output logic expired_o
);

    localparam int unsigned CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clear_i) begin
            cnt_d = '0;
        end else if (en_i && (cnt_q != CNT_LAST)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expired_o = (cnt_q == CNT_LAST);

endmodule

// File: rtl/wb_obi_bridge.sv
// Wishbone slave to OBI master bridge with per-phase timeout and abort draining.
// Latency: stb sampled at edge N with immediate gnt and rvalid gives wb_ack_o in cycle N+3.
// Backpressure: one transaction in flight; new Wishbone strobes wait in IDLE until the OBI side is done.
//
// Ports:
//   clk_i, rst_ni                    single clock, synchronous active-low reset
//   en                               gates acceptance of new Wishbone requests only
//   wb_cyc_i .. wb_byte_en_i         Wishbone request; wb_rdata_o/wb_ack_o/wb_err_o response
//   obi_req_o .. obi_wdata_o         OBI request (held stable until gnt); obi_gnt_i grant
//   obi_rvalid_i, obi_rdata_i        OBI response
module wb_obi_bridge
    import wb_obi_bridge_pkg::*;
#(
    parameter int unsigned       ADDR_W    = 32,
    parameter int unsigned       DATA_W    = 32,
    parameter logic [ADDR_W-1:0] ADDR_BASE = '0,
    parameter int unsigned       TIMEOUT   = TIMEOUT_DEFAULT
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                en,
    input  logic                wb_cyc_i,
    input  logic                wb_stb_i,
    input  logic [ADDR_W-1:0]   wb_addr_i,
    input  logic [DATA_W-1:0]   wb_wdata_i,
    input  logic                wb_wr_en_i,
    input  logic [DATA_W/8-1:0] wb_byte_en_i,
    output logic [DATA_W-1:0]   wb_rdata_o,
    output logic                wb_ack_o,
    output logic                wb_err_o,
    output logic                obi_req_o,
    input  logic                obi_gnt_i,
    output logic [ADDR_W-1:0]   obi_addr_o,
    output logic                obi_wr_en_o,
    output logic [DATA_W/8-1:0] obi_byte_en_o,
    output logic [DATA_W-1:0]   obi_wdata_o,
    input  logic                obi_rvalid_i,
    input  logic [DATA_W-1:0]   obi_rdata_i
);

    // Low 20 address bits come from Wishbone, the rest from ADDR_BASE.
    localparam logic [ADDR_W-1:0] LOW_MASK = {{(ADDR_W-20){1'b0}}, {20{1'b1}}};

    state_e              state_q,   state_d;
    logic [ADDR_W-1:0]   addr_q,    addr_d;
    logic [DATA_W-1:0]   wdata_q,   wdata_d;
    logic                wr_en_q,   wr_en_d;
    logic [DATA_W/8-1:0] be_q,      be_d;
    logic [DATA_W-1:0]   rdata_q,   rdata_d;
    // High in ERR when the timeout hit in REQ, i.e. the slave still owes a grant.
    logic                gnt_owed_q, gnt_owed_d;

    logic cnt_clear;
    logic cnt_en;
    logic cnt_expired;

    wb_obi_timeout #(
        .TIMEOUT (TIMEOUT)
    ) u_timeout (
        .clk_i     (clk_i),
        .rst_ni    (rst_ni),
        .clear_i   (cnt_clear),
        .en_i      (cnt_en),
        .expired_o (cnt_expired)
    );

    assign cnt_en = (state_q == S_REQ) || (state_q == S_RESP);

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        wr_en_d    = wr_en_q;
        be_d       = be_q;
        rdata_d    = rdata_q;
        gnt_owed_d = 1'b0;
        cnt_clear  = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (wb_cyc_i && wb_stb_i && en) begin
                    addr_d    = (ADDR_BASE & ~LOW_MASK) | (wb_addr_i & LOW_MASK);
                    wdata_d   = wb_wdata_i;
                    wr_en_d   = wb_wr_en_i;
                    be_d      = wb_byte_en_i;
                    cnt_clear = 1'b1;
                    state_d   = S_REQ;
                end
            end
            S_REQ: begin
                gnt_owed_d = 1'b1;
                // Abort beats grant and timeout; a grant taken in the abort
                // cycle still leaves a response to be drained.
                if (!wb_cyc_i) begin
                    state_d = obi_gnt_i ? S_DRAIN_RSP : S_DRAIN_GNT;
                end else if (obi_gnt_i) begin
                    cnt_clear = 1'b1;
                    state_d   = S_RESP;
                end else if (cnt_expired) begin
                    state_d = S_ERR;
                end
            end
            S_RESP: begin
                // An rvalid coinciding with the abort completes the transfer;
                // waiting for another one would hang.
                if (!wb_cyc_i) begin
                    state_d = obi_rvalid_i ? S_IDLE : S_DRAIN_RSP;
                end else if (obi_rvalid_i) begin
                    rdata_d = obi_rdata_i;
                    state_d = S_ACK;
                end else if (cnt_expired) begin
                    state_d = S_ERR;
                end
            end
            S_ACK: begin
                state_d = S_IDLE;
            end
            S_ERR: begin
                // obi_req_o stays high here when a grant is owed, so a grant or
                // response landing in this cycle is consumed, not lost.
                if (gnt_owed_q) begin
                    state_d = obi_gnt_i ? S_DRAIN_RSP : S_DRAIN_GNT;
                end else begin
                    state_d = obi_rvalid_i ? S_IDLE : S_DRAIN_RSP;
                end
            end
            S_DRAIN_GNT: begin
                if (obi_gnt_i) begin
                    state_d = S_DRAIN_RSP;
                end
            end
            S_DRAIN_RSP: begin
                if (obi_rvalid_i) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q    <= S_IDLE;
            addr_q     <= '0;
            wdata_q    <= '0;
            wr_en_q    <= 1'b0;
            be_q       <= '0;
            rdata_q    <= '0;
            gnt_owed_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            wr_en_q    <= wr_en_d;
            be_q       <= be_d;
            rdata_q    <= rdata_d;
            gnt_owed_q <= gnt_owed_d;
        end
    end

    assign obi_req_o     = (state_q == S_REQ) || (state_q == S_DRAIN_GNT) ||
                           ((state_q == S_ERR) && gnt_owed_q);
    assign obi_addr_o    = addr_q;
    assign obi_wdata_o   = wdata_q;
    assign obi_wr_en_o   = wr_en_q;
    assign obi_byte_en_o = be_q;
    assign wb_rdata_o    = rdata_q;
    assign wb_ack_o      = (state_q == S_ACK);
    assign wb_err_o      = (state_q == S_ERR);

endmodule

// File: tb/tb_wb_obi_bridge.sv
// Bench for wb_obi_bridge: directed corner cases plus randomized transactions
// checked against a cycle-count model of each transaction's outcome.
// The bench plays both the Wishbone master and the OBI slave.
module tb_wb_obi_bridge;

    localparam int unsigned T    = 8;
    localparam logic [31:0] BASE = 32'h4000_0000;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic        en;
    logic        wb_cyc_i, wb_stb_i, wb_wr_en_i;
    logic [31:0] wb_addr_i, wb_wdata_i, wb_rdata_o;
    logic [3:0]  wb_byte_en_i;
    logic        wb_ack_o, wb_err_o;
    logic        obi_req_o, obi_gnt_i, obi_wr_en_o, obi_rvalid_i;
    logic [31:0] obi_addr_o, obi_wdata_o, obi_rdata_i;
    logic [3:0]  obi_byte_en_o;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk_i = ~clk_i;

    wb_obi_bridge #(
        .ADDR_W    (32),
        .DATA_W    (32),
        .ADDR_BASE (BASE),
        .TIMEOUT   (T)
    ) dut (
        .clk_i         (clk_i),
        .rst_ni        (rst_ni),
        .en            (en),
        .wb_cyc_i      (wb_cyc_i),
        .wb_stb_i      (wb_stb_i),
        .wb_addr_i     (wb_addr_i),
        .wb_wdata_i    (wb_wdata_i),
        .wb_wr_en_i    (wb_wr_en_i),
        .wb_byte_en_i  (wb_byte_en_i),
        .wb_rdata_o    (wb_rdata_o),
        .wb_ack_o      (wb_ack_o),
        .wb_err_o      (wb_err_o),
        .obi_req_o     (obi_req_o),
        .obi_gnt_i     (obi_gnt_i),
        .obi_addr_o    (obi_addr_o),
        .obi_wr_en_o   (obi_wr_en_o),
        .obi_byte_en_o (obi_byte_en_o),
        .obi_wdata_o   (obi_wdata_o),
        .obi_rvalid_i  (obi_rvalid_i),
        .obi_rdata_i   (obi_rdata_i)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    function automatic logic [31:0] map_addr(input logic [31:0] a);
        return (BASE & 32'hFFF0_0000) | (a & 32'h000F_FFFF);
    endfunction

    // Present a request so the bridge samples it at the next edge.
    task automatic present(input logic we, input logic [31:0] a, input logic [31:0] wd,
                           input logic [3:0] be);
        wb_cyc_i     = 1'b1;
        wb_stb_i     = 1'b1;
        en           = 1'b1;
        wb_wr_en_i   = we;
        wb_addr_i    = a;
        wb_wdata_i   = wd;
        wb_byte_en_i = be;
    endtask

    // One full transaction. g = cycles of waiting in the request phase before
    // gnt (0 = first cycle), r = cycles of waiting in the response phase.
    // Cycle c counts from the acceptance edge; the model below derives when
    // req, ack and err should be seen and when the bridge is idle again.
    task automatic run_txn(input logic we, input logic [31:0] a, input logic [31:0] wd,
                           input logic [31:0] rd, input logic [3:0] be,
                           input int g, input int r);
        int gc, rc, ack_c, err_c, end_c;
        gc = 1 + g;
        rc = gc + 1 + r;
        ack_c = -1;
        err_c = -1;
        if (g <= int'(T) - 1) begin
            if (r <= int'(T) - 1) begin
                ack_c = rc + 1;
                end_c = rc + 2;
            end else begin
                err_c = gc + 1 + int'(T);
                end_c = rc + 1;
            end
        end else begin
            err_c = 1 + int'(T);
            end_c = rc + 1;
        end

        present(we, a, wd, be);
        for (int c = 1; c <= end_c; c++) begin
            tick();
            if (c == 1) begin
                check_eq("obi_wr_en", {31'd0, obi_wr_en_o}, {31'd0, we});
                check_eq("obi_be", {28'd0, obi_byte_en_o}, {28'd0, be});
                check_eq("obi_wdata", obi_wdata_o, wd);
                // Toggling en after acceptance must not matter.
                en = 1'($urandom_range(0, 1));
            end
            if (c <= gc) check_eq("obi_addr", obi_addr_o, map_addr(a));
            check_eq("obi_req", {31'd0, obi_req_o}, {31'd0, (c <= gc)});
            check_eq("wb_ack", {31'd0, wb_ack_o}, {31'd0, (c == ack_c)});
            check_eq("wb_err", {31'd0, wb_err_o}, {31'd0, (c == err_c)});
            if (c == ack_c) check_eq("wb_rdata", wb_rdata_o, rd);
            if (c == ack_c || c == err_c) begin
                wb_cyc_i = 1'b0;
                wb_stb_i = 1'b0;
            end
            obi_gnt_i    = (c == gc);
            obi_rvalid_i = (c == rc);
            obi_rdata_i  = (c == rc) ? rd : $urandom;
        end
        obi_gnt_i    = 1'b0;
        obi_rvalid_i = 1'b0;
        en           = 1'b1;
    endtask

    task automatic check_quiet(input string tag);
        check_eq({tag, "_ack"}, {31'd0, wb_ack_o}, 32'd0);
        check_eq({tag, "_err"}, {31'd0, wb_err_o}, 32'd0);
    endtask

    initial begin
        rst_ni = 1'b0;
        en = 1'b0; wb_cyc_i = 1'b0; wb_stb_i = 1'b0; wb_wr_en_i = 1'b0;
        wb_addr_i = '0; wb_wdata_i = '0; wb_byte_en_i = '0;
        obi_gnt_i = 1'b0; obi_rvalid_i = 1'b0; obi_rdata_i = '0;
        repeat (3) tick();

        check_eq("rst_req", {31'd0, obi_req_o}, 32'd0);
        check_eq("rst_ack", {31'd0, wb_ack_o}, 32'd0);
        check_eq("rst_err", {31'd0, wb_err_o}, 32'd0);
        check_eq("rst_wr_en", {31'd0, obi_wr_en_o}, 32'd0);
        check_eq("rst_be", {28'd0, obi_byte_en_o}, 32'd0);
        check_eq("rst_addr", obi_addr_o, 32'd0);
        check_eq("rst_wdata", obi_wdata_o, 32'd0);
        check_eq("rst_rdata", wb_rdata_o, 32'd0);
        rst_ni = 1'b1;
        tick();

        // Read with address remap, immediate grant, rvalid two cycles after gnt.
        run_txn(1'b0, 32'hABC1_2344, 32'h0, 32'hDEAD_BEEF, 4'hF, 0, 1);
        // Write with request held five cycles before grant.
        run_txn(1'b1, 32'h0000_0010, 32'h1234_5678, 32'h0BAD_F00D, 4'b0101, 4, 0);
        // Grant withheld: err at cycle 9, req held until gnt at cycle 20.
        run_txn(1'b0, 32'h0003_0000, 32'h0, 32'h1111_2222, 4'hF, 19, 2);
        // Grant in the last allowed cycle: no error.
        run_txn(1'b0, 32'h0000_0100, 32'h0, 32'h3333_4444, 4'hF, int'(T) - 1, 0);
        // Response in the last allowed cycle, then response timeouts.
        run_txn(1'b1, 32'h0000_0200, 32'hAAAA_5555, 32'h5555_6666, 4'h3, 0, int'(T) - 1);
        run_txn(1'b0, 32'h0000_0300, 32'h0, 32'h7777_8888, 4'hF, 1, int'(T));
        run_txn(1'b0, 32'h0000_0400, 32'h0, 32'h9999_AAAA, 4'hF, 0, int'(T) + 3);
        // Grant arriving in the error cycle itself.
        run_txn(1'b0, 32'h0000_0500, 32'h0, 32'hBBBB_CCCC, 4'hF, int'(T), 0);

        // en low: a pending strobe is never forwarded.
        present(1'b0, 32'h0000_0600, 32'h0, 4'hF);
        en = 1'b0;
        for (int c = 0; c < 4; c++) begin
            tick();
            check_eq("en_gate_req", {31'd0, obi_req_o}, 32'd0);
        end
        wb_cyc_i = 1'b0; wb_stb_i = 1'b0; en = 1'b1;

        // Abort in the response phase; response arrives three cycles later.
        present(1'b0, 32'h0000_0700, 32'h0, 4'hF);
        tick();
        check_eq("abr_req1", {31'd0, obi_req_o}, 32'd1);
        obi_gnt_i = 1'b1;
        tick();
        obi_gnt_i = 1'b0;
        check_eq("abr_req2", {31'd0, obi_req_o}, 32'd0);
        wb_cyc_i = 1'b0; wb_stb_i = 1'b0;
        for (int c = 3; c <= 6; c++) begin
            tick();
            check_quiet("abr_resp");
            check_eq("abr_resp_req", {31'd0, obi_req_o}, 32'd0);
            obi_rvalid_i = (c == 5);
        end
        obi_rvalid_i = 1'b0;
        run_txn(1'b1, 32'h0000_0800, 32'hFEED_0001, 32'h0102_0304, 4'hC, 0, 0);

        // Abort in the request phase together with the grant.
        present(1'b0, 32'h0000_0900, 32'h0, 4'hF);
        tick();
        obi_gnt_i = 1'b1; wb_cyc_i = 1'b0; wb_stb_i = 1'b0;
        tick();
        obi_gnt_i = 1'b0;
        check_eq("abr_gnt_req", {31'd0, obi_req_o}, 32'd0);
        check_quiet("abr_gnt");
        obi_rvalid_i = 1'b1;
        tick();
        obi_rvalid_i = 1'b0;
        check_quiet("abr_gnt2");

        // Abort in the request phase with no grant: request held until gnt.
        present(1'b0, 32'h0000_0A00, 32'h0, 4'hF);
        tick();
        wb_cyc_i = 1'b0; wb_stb_i = 1'b0;
        for (int c = 2; c <= 5; c++) begin
            tick();
            check_quiet("abr_req");
            check_eq("abr_req_hold", {31'd0, obi_req_o}, {31'd0, (c <= 3)});
            obi_gnt_i    = (c == 3);
            obi_rvalid_i = (c == 4);
        end
        obi_gnt_i = 1'b0; obi_rvalid_i = 1'b0;

        // Randomized transactions.
        for (int i = 0; i < 40; i++) begin
            run_txn(1'($urandom_range(0, 1)), $urandom, $urandom, $urandom,
                    4'($urandom_range(0, 15)), $urandom_range(0, 11), $urandom_range(0, 10));
        end

        // Reset while waiting for the response.
        run_txn(1'b0, 32'h0000_0B00, 32'h0, 32'hCAFE_F00D, 4'hF, 0, 0);
        present(1'b1, 32'hFFFF_FFFF, 32'h5A5A_5A5A, 4'hF);
        tick();
        obi_gnt_i = 1'b1;
        tick();
        obi_gnt_i = 1'b0;
        rst_ni = 1'b0;
        tick();
        check_eq("rr_req", {31'd0, obi_req_o}, 32'd0);
        check_eq("rr_ack", {31'd0, wb_ack_o}, 32'd0);
        check_eq("rr_err", {31'd0, wb_err_o}, 32'd0);
        check_eq("rr_wr_en", {31'd0, obi_wr_en_o}, 32'd0);
        check_eq("rr_be", {28'd0, obi_byte_en_o}, 32'd0);
        check_eq("rr_addr", obi_addr_o, 32'd0);
        check_eq("rr_wdata", obi_wdata_o, 32'd0);
        check_eq("rr_rdata", wb_rdata_o, 32'd0);
        wb_cyc_i = 1'b0; wb_stb_i = 1'b0;
        rst_ni = 1'b1;
        tick();
        run_txn(1'b0, 32'h0000_0C00, 32'h0, 32'h1357_9BDF, 4'hF, 2, 3);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
